// File: rtl/vga_pattern_gen.sv
// VGA timing generator with solid, colour-bar, checkerboard and scrolling-bar patterns.
// Counter state (stage 0) feeds one registered output stage (stage 1); every output is aligned.
module vga_pattern_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int COLOR_W     = 3,
  parameter int TILE_SHIFT  = 5,
  parameter int SCROLL_STEP = 4,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int H_W        = $clog2(H_TOTAL),
  localparam int V_W        = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] color,
  output logic [COLOR_W-1:0] pixel,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               de,
  output logic [H_W-1:0]     counter_x,
  output logic [V_W-1:0]     counter_y,
  output logic               line_start,
  output logic               frame_start
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;

  logic [H_W-1:0]     h_cnt_p0;
  logic [V_W-1:0]     v_cnt_p0;
  logic [H_W-1:0]     offset_p0;
  logic [1:0]         mode_sh_p0;
  logic [COLOR_W-1:0] color_sh_p0;

  logic [COLOR_W-1:0] pixel_p1;
  logic               hsync_p1;
  logic               vsync_p1;
  logic               vld_p1;
  logic [H_W-1:0]     cx_p1;
  logic [V_W-1:0]     cy_p1;
  logic               ls_p1;
  logic               fs_p1;

  int                 h_i;
  int                 v_i;
  int                 off_i;
  logic               h_last;
  logic               v_last;
  logic               frame_last;
  logic               active;
  logic [H_W-1:0]     offset_nxt;

  function automatic logic [COLOR_W-1:0] pattern_pix(
    input logic [1:0]         m,
    input logic [COLOR_W-1:0] c,
    input int                 h,
    input int                 v,
    input int                 off
  );
    logic [COLOR_W-1:0] p;
    case (m)
      2'd0:    p = c;
      2'd1:    p = COLOR_W'(h >> (TILE_SHIFT + 1));
      2'd2:    p = ((((h ^ v) >> TILE_SHIFT) & 1) != 0) ? ~c : c;
      default: p = (h >= off && h < off + (1 << TILE_SHIFT)) ? c : '0;
    endcase
    return p;
  endfunction

  function automatic logic sync_level(input int cnt, input int start, input int len,
                                      input bit pol);
    return (cnt >= start && cnt < start + len) ? pol : ~pol;
  endfunction

  assign h_i        = int'(h_cnt_p0);
  assign v_i        = int'(v_cnt_p0);
  assign off_i      = int'(offset_p0);
  assign h_last     = (h_i == H_TOTAL - 1);
  assign v_last     = (v_i == V_TOTAL - 1);
  assign frame_last = h_last && v_last;
  assign active     = (h_i < H_ACTIVE) && (v_i < V_ACTIVE);
  assign offset_nxt = (off_i + SCROLL_STEP >= H_ACTIVE) ? '0 : H_W'(off_i + SCROLL_STEP);

  // Stage 0: raster counters, scroll offset and frame-synchronous shadows of mode/colour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_p0    <= '0;
      v_cnt_p0    <= '0;
      offset_p0   <= '0;
      mode_sh_p0  <= '0;
      color_sh_p0 <= '0;
    end else if (!enable) begin
      h_cnt_p0    <= '0;
      v_cnt_p0    <= '0;
      mode_sh_p0  <= mode;
      color_sh_p0 <= color;
    end else begin
      if (h_last) begin
        h_cnt_p0 <= '0;
        v_cnt_p0 <= v_last ? '0 : v_cnt_p0 + V_W'(1);
      end else begin
        h_cnt_p0 <= h_cnt_p0 + H_W'(1);
      end
      if (frame_last) begin
        mode_sh_p0  <= mode;
        color_sh_p0 <= color;
        offset_p0   <= offset_nxt;
      end
    end
  end

  // Stage 1: registered video outputs, one clock behind the counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_p1 <= '0;
      hsync_p1 <= ~HS_POL;
      vsync_p1 <= ~VS_POL;
      vld_p1   <= 1'b0;
      cx_p1    <= '0;
      cy_p1    <= '0;
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end else if (!enable) begin
      pixel_p1 <= '0;
      hsync_p1 <= ~HS_POL;
      vsync_p1 <= ~VS_POL;
      vld_p1   <= 1'b0;
      cx_p1    <= '0;
      cy_p1    <= '0;
      ls_p1    <= 1'b0;
      fs_p1    <= 1'b0;
    end else begin
      pixel_p1 <= active ? pattern_pix(mode_sh_p0, color_sh_p0, h_i, v_i, off_i) : '0;
      hsync_p1 <= sync_level(h_i, HS_START, H_SYNC, HS_POL);
      vsync_p1 <= sync_level(v_i, VS_START, V_SYNC, VS_POL);
      vld_p1   <= active;
      cx_p1    <= h_cnt_p0;
      cy_p1    <= v_cnt_p0;
      ls_p1    <= (h_i == 0);
      fs_p1    <= (h_i == 0) && (v_i == 0);
    end
  end

  assign pixel       = pixel_p1;
  assign hsync_out   = hsync_p1;
  assign vsync_out   = vsync_p1;
  assign de          = vld_p1;
  assign counter_x   = cx_p1;
  assign counter_y   = cy_p1;
  assign line_start  = ls_p1;
  assign frame_start = fs_p1;

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 H_ACTIVE, 640, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync and back porch widths in clocks.
REQ-003 V_ACTIVE, 480, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync and back porch widths in lines.
REQ-005 HS_POL / VS_POL, 0 / 0, active level of hsync_out / vsync_out.
REQ-006 COLOR_W, 3, pixel bits.
REQ-007 TILE_SHIFT, 5, log2 of checker tile and scroll bar size in pixels.
REQ-008 SCROLL_STEP, 4, scroll bar advance in pixels per frame.
REQ-009 clk  in  1  pixel clock.
REQ-010 rst_n  in  1  reset; asynchronous, active-low.
REQ-011 enable  in  1  run timing when high.
REQ-012 mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 scroll.
REQ-013 color  in  COLOR_W  foreground colour.
REQ-014 pixel  out  COLOR_W  registered pixel value.
REQ-015 hsync_out / vsync_out  out  1 each  registered syncs.
REQ-016 de  out  1  registered display-enable (active region).
REQ-017 counter_x / counter_y  out  clog2(H_TOTAL) / clog2(V_TOTAL)  coordinate of the current output pixel.
REQ-018 line_start / frame_start  out  1 each  one-clock pulses.

Function
REQ-019 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; all comparisons use these totals.
REQ-020 h_cnt counts 0..H_TOTAL-1 each clock while enable=1, wraps to 0; v_cnt increments on h wrap, wraps to 0 after V_TOTAL-1.
REQ-021 Active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync active for the analogous v_cnt range.
REQ-022 All outputs registered; latency exactly 1 clock from counter state; pixel, syncs, de, counter_x/y, line_start, frame_start mutually aligned.
REQ-023 line_start pulses with output counter_x=0; frame_start pulses with output (0,0), coincident with line_start.
REQ-024 Outside active region pixel=0.
REQ-025 Mode 0: pixel=color.
REQ-026 Mode 1: pixel=h_cnt[TILE_SHIFT+COLOR_W:TILE_SHIFT+1] (bar index, wraps mod 2^COLOR_W).
REQ-027 Mode 2: pixel=color when h_cnt[TILE_SHIFT]^v_cnt[TILE_SHIFT]=0, else ~color.
REQ-028 Mode 3: pixel=color when offset <= h_cnt < offset+2^TILE_SHIFT, else 0; bar clipped at H_ACTIVE, no wrap of bar body.
REQ-029 offset increments by SCROLL_STEP at each frame wrap; if result >= H_ACTIVE it becomes 0.
REQ-030 mode and color sampled into shadow registers on the clock where (h_cnt,v_cnt)=(H_TOTAL-1,V_TOTAL-1), and every clock enable=0; pattern logic uses shadows only (no mid-frame tearing).
REQ-031 enable=0: counters forced to 0, offset held, outputs on next clock: syncs inactive, de=0, pixel=0, pulses 0, counters 0.
REQ-032 enable 0->1: counting starts at (0,0); frame_start pulses 1 clock after the enable rising edge is sampled.

Reset
REQ-033 rst_n low asynchronously clears h_cnt, v_cnt, offset, shadow mode/color, de, pixel, pulses, counter_x/y to 0 and drives syncs to their inactive level (~HS_POL, ~VS_POL).
REQ-034 After rst_n deasserts, behaviour equals enable rising from (0,0); reset mid-frame discards the frame.

Verification (params H 8/2/3/3, V 4/1/2/1, TILE_SHIFT=1, SCROLL_STEP=2, COLOR_W=3)
REQ-035 Timing: enable=1, mode 0, color=5 -> frame period 128 clocks; hsync low for output x=10..12; vsync low for y=5..6 (all x); de high 32 clocks per frame; pixel=5 when de else 0.
REQ-036 Pulses: frame_start once per 128 clocks, with counter_x=0,counter_y=0; line_start every 16 clocks.
REQ-037 Patterns: mode 2, color=3 -> line 0 pixels 3,3,4,4,3,3,4,4; line 2 inverted; mode 1 -> line 0 pixels 0,0,0,0,1,1,1,1.
REQ-038 Shadowing: change mode 0->2 at output (4,1) -> rest of frame stays mode 0; checker from next frame_start.
REQ-039 Scroll: mode 3, color=7 -> frame0 bar at x=0..1, frame1 x=2..3, frame3 x=6..7, frame4 x=0..1 (wrap).
REQ-040 Reset/enable: rst_n low mid-line -> same-cycle syncs high, pixel=0; release -> first frame_start 1 clock after first enabled edge; enable low 3 clocks -> de=0, counters 0, restart at (0,0).
